// File: rtl/nios2_jtag_ocimem_access_pkg.sv
// Shared types and constants for the JTAG on-chip debug memory access block.
package nios2_jtag_ocimem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } ocimem_state_t;

  localparam int JDO_W         = 38;
  localparam int JDO_RDREQ_BIT = 25;
  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_WDATA_LSB = 3;
  localparam int DATA_W        = 32;

endpackage

// File: rtl/nios2_jtag_ocimem_rdlat_cnt.sv
// Read-latency counter: loaded on read acceptance, counts down to zero.
module nios2_jtag_ocimem_rdlat_cnt (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       done
);

  logic [2:0] cnt;

  // Load on request, otherwise decrement until zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign done = (cnt == 3'd0);

endmodule

// File: rtl/nios2_jtag_ocimem_access.sv
// Executes debugger reads/writes on the on-chip debug memory with address
// auto-increment, returning results through MonDReg/monitor_ready/monitor_error.
module nios2_jtag_ocimem_access
  import nios2_jtag_ocimem_access_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  // The counter starts at RD_LATENCY-1 on the acceptance edge so capture
  // lands exactly RD_LATENCY edges after acceptance.
  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);

  ocimem_state_t state, state_nxt;

  logic              addr_legal;
  logic              in_idle;
  logic              cmd_any;
  logic              cmd_multi;
  logic              accept_a;
  logic              err_set;
  logic              lat_load;
  logic              lat_done;
  logic [ADDR_W-1:0] jdo_addr;
  logic [DATA_W-1:0] jdo_wdata;
  logic              unused_jdo_bits;

  assign jdo_addr        = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_wdata       = jdo[JDO_WDATA_LSB +: DATA_W];
  assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_WDATA_LSB+DATA_W], jdo[JDO_WDATA_LSB-1:0]};

  assign addr_legal = (32'(MonAReg) < 32'(DEPTH));
  assign in_idle    = (state == ST_IDLE);
  assign cmd_any    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign cmd_multi  = (take_action_ocimem_a & take_no_action_ocimem_a) |
                      (take_action_ocimem_a & take_action_ocimem_b) |
                      (take_no_action_ocimem_a & take_action_ocimem_b);
  assign accept_a   = in_idle & take_action_ocimem_a;
  // Dropped commands (busy or lower priority) and illegal targets raise the error.
  assign err_set    = (~in_idle & cmd_any) | (in_idle & cmd_multi) |
                      (((state == ST_RD_REQ) | (state == ST_WR_REQ)) & ~addr_legal);

  nios2_jtag_ocimem_rdlat_cnt u_rdlat_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .done     (lat_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and memory request outputs.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = MonAReg;
    mem_wdata = MonDReg;
    lat_load  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          if (jdo[JDO_RDREQ_BIT]) state_nxt = ST_RD_REQ;
        end else if (take_no_action_ocimem_a) begin
          state_nxt = ST_RD_REQ;
        end else if (take_action_ocimem_b) begin
          state_nxt = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!addr_legal) begin
          state_nxt = ST_IDLE;
        end else begin
          mem_rd = 1'b1;
          if (!mem_waitrequest) begin
            lat_load  = 1'b1;
            state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (lat_done) state_nxt = ST_IDLE;
      end
      ST_WR_REQ: begin
        if (!addr_legal) begin
          state_nxt = ST_IDLE;
        end else begin
          mem_wr = 1'b1;
          if (!mem_waitrequest) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Monitor registers: address, data, ready and sticky error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            MonAReg       <= jdo_addr;
            monitor_ready <= ~jdo[JDO_RDREQ_BIT];
          end else if (take_no_action_ocimem_a) begin
            MonAReg       <= MonAReg + ADDR_W'(1);
            monitor_ready <= 1'b0;
          end else if (take_action_ocimem_b) begin
            MonDReg       <= jdo_wdata;
            monitor_ready <= 1'b0;
          end
        end
        ST_RD_REQ: begin
          if (!addr_legal) monitor_ready <= 1'b1;
        end
        ST_RD_WAIT: begin
          if (lat_done) begin
            MonDReg       <= mem_rdata;
            monitor_ready <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (!addr_legal || !mem_waitrequest) begin
            MonAReg       <= MonAReg + ADDR_W'(1);
            monitor_ready <= 1'b1;
          end
        end
        default: ;
      endcase
      if (err_set) begin
        monitor_error <= 1'b1;
      end else if (accept_a) begin
        monitor_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios2_jtag_ocimem_access.sv
// Self-checking bench for nios2_jtag_ocimem_access with a behavioural memory.
module tb_nios2_jtag_ocimem_access;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int LAT    = 2;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_waitrequest;
  logic [31:0] mem_rdata;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  nios2_jtag_ocimem_access #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .mem_rd                  (mem_rd),
    .mem_wr                  (mem_wr),
    .mem_waitrequest         (mem_waitrequest),
    .mem_rdata               (mem_rdata),
    .MonAReg                 (MonAReg),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side state (owned by the responder processes).
  logic [31:0] mem [256];
  bit          mem_filled = 1'b0;
  int          stall_cfg = 0;
  int          req_run = 0;
  logic [7:0]  run_addr;
  int          addr_moved = 0;
  int          rd_total = 0;
  int          wr_total = 0;
  int          both_high = 0;
  bit          acc_rd = 1'b0;
  bit          acc_wr = 1'b0;
  logic [7:0]  acc_addr;
  logic [31:0] acc_wdata;
  int          rd_cnt = 0;
  logic [7:0]  rd_addr;

  // Reference model state (owned by the main initial block).
  logic [31:0] ref_mem [256];
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic        m_err;
  int          n_checks;
  int          n_pass;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [37:0] mk_jdo_a(input logic [7:0] addr, input logic rd);
    logic [37:0] j;
    j = {6'($urandom), $urandom};
    j[25] = rd;
    j[33:26] = addr;
    return j;
  endfunction

  function automatic logic [37:0] mk_jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = {6'($urandom), $urandom};
    j[34:3] = d;
    return j;
  endfunction

  // Decide waitrequest for the coming edge and note what the memory accepts.
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      mem_waitrequest = (req_run < stall_cfg);
      if (req_run == 0) run_addr = mem_addr;
      else if (mem_addr !== run_addr) addr_moved++;
      req_run++;
    end else begin
      mem_waitrequest = 1'b0;
      req_run = 0;
    end
    if (mem_rd) rd_total++;
    if (mem_wr) wr_total++;
    if (mem_rd && mem_wr) both_high++;
    acc_rd    = mem_rd && !mem_waitrequest;
    acc_wr    = mem_wr && !mem_waitrequest;
    acc_addr  = mem_addr;
    acc_wdata = mem_wdata;
  end

  // Memory array; read data is valid only in the cycle ending LAT edges after acceptance.
  always @(posedge clk) begin
    if (!mem_filled) begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      mem_filled = 1'b1;
    end
    if (acc_wr) mem[acc_addr] = acc_wdata;
    if (acc_rd) begin
      rd_cnt  = LAT;
      rd_addr = acc_addr;
    end else if (rd_cnt > 0) begin
      rd_cnt--;
    end
    #1;
    mem_rdata = (rd_cnt == 1) ? mem[rd_addr] : $urandom;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic a, input logic na, input logic b, input logic [37:0] j);
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a    = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b    = b;
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    jdo = {6'($urandom), $urandom};
  endtask

  task automatic wait_ready(output int k);
    k = 0;
    while (monitor_ready !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    logic [83:0] outs;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {mem_rd, mem_wr, mem_addr, mem_wdata, MonAReg, MonDReg, monitor_ready, monitor_error};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else n_pass++;
    reset_n = 1'b1;
    m_addr = '0; m_data = '0; m_err = 1'b0;
  endtask

  task automatic test_read_timing();
    int k, rd0;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(8'h10, 1'b0));
    pulse(1'b0, 1'b0, 1'b1, mk_jdo_b(32'hDEADBEEF));
    wait_ready(k);
    ref_mem[8'h10] = 32'hDEADBEEF;
    stall_cfg = 0;
    rd0 = rd_total;
    @(negedge clk);
    jdo = mk_jdo_a(8'h10, 1'b1);
    take_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    n_checks++;
    if ({mem_rd, mem_addr, monitor_ready} !== {1'b1, 8'h10, 1'b0})
      $display("FAIL rd_issue: got rd=%b addr=%h rdy=%b want rd=1 addr=10 rdy=0", mem_rd, mem_addr, monitor_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({mem_rd, monitor_ready} !== 2'b00)
      $display("FAIL rd_one_cycle: got rd=%b rdy=%b want 0 0", mem_rd, monitor_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (monitor_ready !== 1'b0) $display("FAIL rd_early_ready: got %b want 0", monitor_ready); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({monitor_ready, MonDReg} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL rd_capture: got rdy=%b data=%h want 1 deadbeef", monitor_ready, MonDReg);
    else n_pass++;
    n_checks++;
    if (rd_total - rd0 !== 1) $display("FAIL rd_cycles: got %0d want 1", rd_total - rd0); else n_pass++;
    m_addr = 8'h10; m_data = 32'hDEADBEEF; m_err = 1'b0;
  endtask

  task automatic test_write_burst();
    int k;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(8'h20, 1'b0));
    n_checks++;
    if ({MonAReg, monitor_ready, monitor_error} !== {8'h20, 1'b1, 1'b0})
      $display("FAIL wr_load: got addr=%h rdy=%b err=%b want 20 1 0", MonAReg, monitor_ready, monitor_error);
    else n_pass++;
    pulse(1'b0, 1'b0, 1'b1, mk_jdo_b(32'h11111111));
    wait_ready(k);
    pulse(1'b0, 1'b0, 1'b1, mk_jdo_b(32'h22222222));
    wait_ready(k);
    n_checks++;
    if (mem[8'h20] !== 32'h11111111) $display("FAIL wr_mem20: got %h want 11111111", mem[8'h20]); else n_pass++;
    n_checks++;
    if (mem[8'h21] !== 32'h22222222) $display("FAIL wr_mem21: got %h want 22222222", mem[8'h21]); else n_pass++;
    n_checks++;
    if ({MonAReg, MonDReg} !== {8'h22, 32'h22222222})
      $display("FAIL wr_regs: got addr=%h data=%h want 22 22222222", MonAReg, MonDReg);
    else n_pass++;
    ref_mem[8'h20] = 32'h11111111;
    ref_mem[8'h21] = 32'h22222222;
    m_addr = 8'h22; m_data = 32'h22222222; m_err = 1'b0;
  endtask

  task automatic test_read_stall();
    int k, rd0, mv0;
    logic [7:0] a;
    a = 8'($urandom_range(0, DEPTH - 1));
    stall_cfg = 3;
    rd0 = rd_total; mv0 = addr_moved;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(a, 1'b1));
    wait_ready(k);
    stall_cfg = 0;
    n_checks++;
    if (rd_total - rd0 !== 4) $display("FAIL stall_rd_cycles: got %0d want 4", rd_total - rd0); else n_pass++;
    n_checks++;
    if (addr_moved - mv0 !== 0 || run_addr !== a)
      $display("FAIL stall_addr: got moved=%0d addr=%h want 0 %h", addr_moved - mv0, run_addr, a);
    else n_pass++;
    n_checks++;
    if (k !== 1 + 3 + LAT) $display("FAIL stall_latency: got %0d want %0d", k, 1 + 3 + LAT); else n_pass++;
    n_checks++;
    if (MonDReg !== ref_mem[a]) $display("FAIL stall_data: got %h want %h", MonDReg, ref_mem[a]); else n_pass++;
    m_addr = a; m_data = ref_mem[a]; m_err = 1'b0;
  endtask

  task automatic test_illegal_addr();
    int k, rd0, wr0;
    logic [31:0] d;
    rd0 = rd_total; wr0 = wr_total;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(8'hC8, 1'b1));
    wait_ready(k);
    n_checks++;
    if (k !== 1 || rd_total - rd0 !== 0)
      $display("FAIL ill_rd_access: got lat=%0d rds=%0d want 1 0", k, rd_total - rd0);
    else n_pass++;
    n_checks++;
    if ({monitor_error, monitor_ready, MonDReg, MonAReg} !== {1'b1, 1'b1, m_data, 8'hC8})
      $display("FAIL ill_rd_regs: got err=%b rdy=%b data=%h addr=%h want 1 1 %h c8",
               monitor_error, monitor_ready, MonDReg, MonAReg, m_data);
    else n_pass++;
    d = $urandom;
    pulse(1'b0, 1'b0, 1'b1, mk_jdo_b(d));
    wait_ready(k);
    n_checks++;
    if ({wr_total - wr0 == 0, MonAReg, MonDReg, monitor_error} !== {1'b1, 8'hC9, d, 1'b1})
      $display("FAIL ill_wr: got wrs=%0d addr=%h data=%h err=%b want 0 c9 %h 1",
               wr_total - wr0, MonAReg, MonDReg, monitor_error, d);
    else n_pass++;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(8'h05, 1'b0));
    n_checks++;
    if (monitor_error !== 1'b0) $display("FAIL ill_err_clear: got %b want 0", monitor_error); else n_pass++;
    m_addr = 8'h05; m_data = d; m_err = 1'b0;
  endtask

  task automatic test_wrap_busy();
    int k, wr0;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(8'hFF, 1'b0));
    stall_cfg = 0;
    wr0 = wr_total;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    n_checks++;
    if ({mem_rd, mem_addr, MonAReg} !== {1'b1, 8'h00, 8'h00})
      $display("FAIL wrap_issue: got rd=%b addr=%h mona=%h want 1 00 00", mem_rd, mem_addr, MonAReg);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (monitor_error !== 1'b0) $display("FAIL wrap_no_err: got %b want 0", monitor_error); else n_pass++;
    jdo = mk_jdo_b($urandom);
    take_action_ocimem_b = 1'b1;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    wait_ready(k);
    n_checks++;
    if ({monitor_error, MonDReg, MonAReg} !== {1'b1, ref_mem[0], 8'h00})
      $display("FAIL busy_drop: got err=%b data=%h addr=%h want 1 %h 00", monitor_error, MonDReg, MonAReg, ref_mem[0]);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_total - wr0 !== 0) $display("FAIL busy_no_write: got %0d want 0", wr_total - wr0); else n_pass++;
    m_addr = 8'h00; m_data = ref_mem[0]; m_err = 1'b1;
  endtask

  task automatic test_priority();
    int k, wr0, rd0;
    logic [7:0] a;
    a = 8'($urandom_range(0, DEPTH - 2));
    wr0 = wr_total;
    pulse(1'b1, 1'b0, 1'b1, {mk_jdo_a(a, 1'b0)});
    wait_ready(k);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({MonAReg, monitor_error, MonDReg, wr_total - wr0 == 0} !== {a, 1'b1, m_data, 1'b1})
      $display("FAIL prio_a_b: got addr=%h err=%b data=%h wrs=%0d want %h 1 %h 0",
               MonAReg, monitor_error, MonDReg, wr_total - wr0, a, m_data);
    else n_pass++;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(a, 1'b0));
    n_checks++;
    if (monitor_error !== 1'b0) $display("FAIL prio_clear: got %b want 0", monitor_error); else n_pass++;
    wr0 = wr_total;
    pulse(1'b0, 1'b1, 1'b1, mk_jdo_b($urandom));
    wait_ready(k);
    n_checks++;
    if ({MonAReg, MonDReg, monitor_error, wr_total - wr0 == 0} !== {a + 8'd1, ref_mem[a + 8'd1], 1'b1, 1'b1})
      $display("FAIL prio_na_b: got addr=%h data=%h err=%b wrs=%0d want %h %h 1 0",
               MonAReg, MonDReg, monitor_error, wr_total - wr0, a + 8'd1, ref_mem[a + 8'd1]);
    else n_pass++;
    rd0 = rd_total;
    pulse(1'b1, 1'b1, 1'b0, mk_jdo_a(8'h33, 1'b0));
    repeat (3) @(negedge clk);
    n_checks++;
    if ({MonAReg, monitor_error, rd_total - rd0 == 0} !== {8'h33, 1'b1, 1'b1})
      $display("FAIL prio_a_na: got addr=%h err=%b rds=%0d want 33 1 0", MonAReg, monitor_error, rd_total - rd0);
    else n_pass++;
    m_addr = 8'h33; m_data = ref_mem[a + 8'd1]; m_err = 1'b1;
  endtask

  task automatic test_random();
    int k, op, stall, exp_lat, exp_rd, exp_wr, rd0, wr0;
    logic [7:0]  addr, tgt;
    logic        rd;
    logic [31:0] wd;
    logic [37:0] j;
    for (int i = 0; i < 80; i++) begin
      op    = $urandom_range(0, 2);
      stall = $urandom_range(0, 3);
      addr  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(DEPTH, 255)) : 8'($urandom_range(0, DEPTH - 1));
      rd    = 1'($urandom_range(0, 1));
      wd    = $urandom;
      exp_rd = 0; exp_wr = 0; tgt = m_addr;
      if (op == 0) begin
        m_addr = addr; m_err = 1'b0; exp_lat = 0;
        if (rd) begin
          if (int'(addr) < DEPTH) begin m_data = ref_mem[addr]; exp_lat = 1 + stall + LAT; exp_rd = stall + 1; end
          else begin m_err = 1'b1; exp_lat = 1; end
        end
        j = mk_jdo_a(addr, rd);
      end else if (op == 1) begin
        m_addr = m_addr + 8'd1;
        if (int'(m_addr) < DEPTH) begin m_data = ref_mem[m_addr]; exp_lat = 1 + stall + LAT; exp_rd = stall + 1; end
        else begin m_err = 1'b1; exp_lat = 1; end
        j = mk_jdo_a(addr, rd);
      end else begin
        m_data = wd;
        if (int'(m_addr) < DEPTH) begin ref_mem[m_addr] = wd; exp_lat = 1 + stall; exp_wr = stall + 1; end
        else begin m_err = 1'b1; exp_lat = 1; end
        m_addr = m_addr + 8'd1;
        j = mk_jdo_b(wd);
      end
      stall_cfg = stall;
      rd0 = rd_total; wr0 = wr_total;
      pulse(op == 0, op == 1, op == 2, j);
      wait_ready(k);
      stall_cfg = 0;
      n_checks++;
      if (k !== exp_lat) $display("FAIL rnd_latency[%0d] op=%0d: got %0d want %0d", i, op, k, exp_lat); else n_pass++;
      n_checks++;
      if ({MonAReg, MonDReg, monitor_error} !== {m_addr, m_data, m_err})
        $display("FAIL rnd_regs[%0d] op=%0d: got addr=%h data=%h err=%b want %h %h %b",
                 i, op, MonAReg, MonDReg, monitor_error, m_addr, m_data, m_err);
      else n_pass++;
      n_checks++;
      if (rd_total - rd0 !== exp_rd || wr_total - wr0 !== exp_wr)
        $display("FAIL rnd_access[%0d] op=%0d: got rd=%0d wr=%0d want %0d %0d",
                 i, op, rd_total - rd0, wr_total - wr0, exp_rd, exp_wr);
      else n_pass++;
      if (op == 2) begin
        n_checks++;
        if (mem[tgt] !== ref_mem[tgt]) $display("FAIL rnd_mem[%0d]: got %h want %h", i, mem[tgt], ref_mem[tgt]);
        else n_pass++;
      end
    end
    k = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) k++;
    n_checks++;
    if (k !== 0) $display("FAIL rnd_mem_image: got %0d differing words want 0", k); else n_pass++;
    n_checks++;
    if (both_high !== 0) $display("FAIL rd_wr_exclusive: got %0d overlapping cycles want 0", both_high); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int k;
    bit bad;
    logic [83:0] outs;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(8'h10, 1'b0));
    pulse(1'b0, 1'b0, 1'b1, mk_jdo_b(32'hDEADBEEF));
    wait_ready(k);
    ref_mem[8'h10] = 32'hDEADBEEF;
    stall_cfg = 10;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(8'h10, 1'b1));
    n_checks++;
    if (mem_rd !== 1'b1) $display("FAIL rst_pre_rd: got %b want 1", mem_rd); else n_pass++;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    outs = {mem_rd, mem_wr, mem_addr, mem_wdata, MonAReg, MonDReg, monitor_ready, monitor_error};
    n_checks++;
    if (outs !== '0) $display("FAIL rst_mid_outputs: got %h want 0", outs); else n_pass++;
    reset_n = 1'b1;
    stall_cfg = 0;
    @(negedge clk);
    n_checks++;
    if ({mem_rd, monitor_ready} !== 2'b00) $display("FAIL rst_idle: got rd=%b rdy=%b want 0 0", mem_rd, monitor_ready);
    else n_pass++;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(8'h10, 1'b1));
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (MonDReg !== 32'h0 || monitor_ready !== 1'b0 || mem_rd !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL rst_late_data: got data=%h rdy=%b want 0 0", MonDReg, monitor_ready); else n_pass++;
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(8'h10, 1'b1));
    wait_ready(k);
    n_checks++;
    if ({MonDReg, k == 1 + LAT} !== {32'hDEADBEEF, 1'b1})
      $display("FAIL rst_recover: got data=%h lat=%0d want deadbeef %0d", MonDReg, k, 1 + LAT);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    jdo      = '0;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_read_timing();
    test_write_burst();
    test_read_stall();
    test_illegal_addr();
    test_wrap_busy();
    test_priority();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
